seq_hit_monitor: RTL and testbench
==================================

Name: seq_hit_monitor

Overview:
- Downstream consumer of the 1010 overlapping sequence detector. Takes the detector's one-cycle Moore match output and counts matches over fixed windows.
- At each window end it publishes a snapshot through a valid/ready handshake and raises a threshold alarm.
- Also keeps a saturating lifetime total, so software/upstream logic can monitor pattern density without sampling every cycle.

Parameters:
- CNT_W, 8: width of window count and snapshot data.
- TOT_W, 16: width of lifetime total counter.
- WIN_LEN, 64: window length in clk cycles (>=2).
- THRESH, 4: alarm when window count >= THRESH (1..2^CNT_W-1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  1 = monitoring; 0 = idle, partial window discarded.
- hit_in  in  1  detector match; each cycle high = one hit (no edge detect).
- snap_data  out  CNT_W  hits in last completed window.
- snap_valid  out  1  snapshot pending.
- snap_ready  in  1  consumer accepts snapshot.
- overrun  out  1  sticky: window ended while snapshot still pending.
- alarm  out  1  last completed window count >= THRESH.
- total_cnt  out  TOT_W  saturating lifetime hits while enabled.
- clr  in  1  synchronous clear of total_cnt and overrun (not of window).

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - win_tmr, win_cnt, snap_data, total_cnt = 0.
  - snap_valid, overrun, alarm = 0.
  - rst has priority over all inputs, including mid-window and mid-handshake.
- FSM, two states:
  - IDLE: win_tmr=win_cnt=0; hit_in ignored. enable=1 -> RUN next cycle. The first counted hit is the one sampled in the first RUN cycle.
  - RUN:
    - Each cycle with hit_in=1: win_cnt += 1 and total_cnt += 1, both saturating at all-ones.
    - win_tmr increments every cycle.
    - enable=0 -> IDLE; the current cycle's hit is not counted; partial window discarded; no snapshot.
- Window end (RUN and win_tmr==WIN_LEN-1):
  - Final count = sat(win_cnt + hit_in).
  - win_cnt <= 0, win_tmr <= 0; the next window starts the next cycle with no gap.
  - alarm <= (final count >= THRESH); alarm holds until the next window end.
  - If snap_valid=0, or snap_valid=1 with snap_ready=1 this cycle: snap_data <= final count, snap_valid <= 1.
  - Else: overrun <= 1; snap_data keeps the old, unconsumed value.
- Handshake:
  - Transfer occurs when snap_valid && snap_ready.
  - With no simultaneous window end: snap_valid <= 0 next cycle.
  - snap_data stable while snap_valid=1 and not transferred.
  - snap_ready while snap_valid=0 has no effect.
- clr=1:
  - total_cnt <= 0 and overrun <= 0.
  - If a hit arrives the same cycle, clr wins: total_cnt=0.
  - If a window end overruns the same cycle, overrun=1 (set wins).
- Latency: hit_in to total_cnt is 1 cycle; window-end cycle to snap_valid/alarm is 1 cycle.
- Going to IDLE does not clear snap_valid, snap_data, alarm or total_cnt.

Optional Feature:
- Macro SEQ_HIT_MON_TS_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter (cleared by rst).
  - Adds output port last_hit_ts [31:0]: timestamp of the most recent counted hit, updated the cycle after the hit; 0 after reset.
  - Adds output last_hit_ts_vld, set on the first counted hit.
- Undefined: the ports and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_mon_pkg:
  - state typedef (IDLE, RUN).
  - default constants for CNT_W/TOT_W/WIN_LEN/THRESH.
  - function computing the win_tmr width, $clog2(WIN_LEN).
- One sub-module, sat_counter: parameterised width; inc, clr, value; saturates at all-ones. Instanced for win_cnt and total_cnt.

Test Plan (WIN_LEN=8, THRESH=2, CNT_W=3):
- Reset, then enable=1, drive serial 1010100 into the detector feeding hit_in (hits in 2 windows-worth as produced), snap_ready=1 -> snap_valid pulses once per 8 cycles; snap_data equals the hit count per window; total_cnt equals the sum.
- Hit_in high on all 8 cycles of a window -> win_cnt saturates at 7; snap_data=7; alarm=1.
- snap_ready=0 across two window ends -> first snapshot held unchanged; overrun=1 one cycle after the second end. clr=1 -> overrun=0, total_cnt=0.
- Hit on the window-end cycle (win_tmr=7) with win_cnt=1 -> snap_data=2; alarm=1. The next window's win_cnt starts at 0.
- enable drops at win_tmr=5 with 3 hits counted -> no snapshot; IDLE. Re-enable -> the full 8-cycle window restarts.
- rst asserted with snap_valid=1 and alarm=1 -> all outputs 0 next cycle; snapshot lost.

Source files
------------

// File: rtl/seq_hit_monitor_pkg.sv
// Shared types and defaults for the sequence-hit monitor.
// Optional timestamp feature is enabled by defining SEQ_HIT_MON_TS_EN.
package seq_mon_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TOT_W   = 16;
  localparam int DEF_WIN_LEN = 64;
  localparam int DEF_THRESH  = 4;

  // Width of the window timer; it only has to reach WIN_LEN-1.
  function automatic int tmr_width(input int win_len);
    return (win_len < 2) ? 1 : $clog2(win_len);
  endfunction

endpackage

// File: rtl/seq_hit_monitor_if.sv
// Snapshot handshake bundle.
// Valid/ready: a transfer happens on every rising clk edge where snap_valid
// and snap_ready are both high; the producer holds snap_data stable while
// snap_valid is high and the transfer has not yet happened; snap_ready
// while snap_valid is low has no effect.
import seq_mon_pkg::*;

interface seq_hit_monitor_if #(
  parameter int CNT_W = DEF_CNT_W
);
  logic [CNT_W-1:0] snap_data;
  logic             snap_valid;
  logic             snap_ready;

  modport master (output snap_data, output snap_valid, input snap_ready);
  modport slave  (input snap_data, input snap_valid, output snap_ready);
endinterface

// File: rtl/seq_hit_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear beats increment; the value sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_value;

  // Count up, holding at all-ones; rst and clear both return to zero.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_value <= '0;
    end else if (i_inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + W'(1);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/seq_hit_monitor.sv
// Counts detector hits over fixed windows, publishes a per-window snapshot
// over a valid/ready bundle, raises a threshold alarm and keeps a saturating
// lifetime total. Define SEQ_HIT_MON_TS_EN to add a last-hit timestamp.
import seq_mon_pkg::*;

module seq_hit_monitor #(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TOT_W   = DEF_TOT_W,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int THRESH  = DEF_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_hit_in,
  input  logic              i_clr,
  seq_hit_monitor_if.master snap,
  output logic              o_overrun,
  output logic              o_alarm,
  output logic [TOT_W-1:0]  o_total_cnt,
`ifdef SEQ_HIT_MON_TS_EN
  output logic [31:0]       o_last_hit_ts,
  output logic              o_last_hit_ts_vld,
`endif
  output state_t            o_state
);

  localparam int TMR_W = tmr_width(WIN_LEN);

  state_t           r_state;
  logic [TMR_W-1:0] r_win_tmr;
  logic [CNT_W-1:0] r_snap_data;
  logic             r_snap_valid;
  logic             r_overrun;
  logic             r_alarm;

  logic             w_active;
  logic             w_hit;
  logic             w_win_end;
  logic             w_xfer;
  logic             w_overrun_set;
  logic [CNT_W-1:0] w_win_cnt;
  logic [CNT_W-1:0] w_final;

  // A cycle only counts while running and still enabled; a drop of enable
  // discards the current cycle together with the partial window.
  assign w_active      = (r_state == RUN) && i_enable;
  assign w_hit         = w_active && i_hit_in;
  assign w_win_end     = w_active && (r_win_tmr == TMR_W'(WIN_LEN - 1));
  assign w_xfer        = r_snap_valid && snap.snap_ready;
  assign w_overrun_set = w_win_end && r_snap_valid && !snap.snap_ready;
  assign w_final       = (w_hit && (w_win_cnt != {CNT_W{1'b1}})) ?
                         (w_win_cnt + CNT_W'(1)) : w_win_cnt;

  // The window-end hit is folded into w_final, so the counter just restarts.
  sat_counter #(.W(CNT_W)) u_win_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hit && !w_win_end),
    .i_clr   (!w_active || w_win_end),
    .o_value (w_win_cnt)
  );

  sat_counter #(.W(TOT_W)) u_total_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hit),
    .i_clr   (i_clr),
    .o_value (o_total_cnt)
  );

  // Control FSM, window timer and registered snapshot/alarm/overrun outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_win_tmr    <= '0;
      r_snap_data  <= '0;
      r_snap_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_win_tmr <= '0;
          if (i_enable) r_state <= RUN;
        end
        RUN: begin
          if (!i_enable) begin
            r_state   <= IDLE;
            r_win_tmr <= '0;
          end else if (w_win_end) begin
            r_win_tmr <= '0;
          end else begin
            r_win_tmr <= r_win_tmr + TMR_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_win_tmr <= '0;
        end
      endcase

      if (w_win_end) begin
        r_alarm <= (w_final >= CNT_W'(THRESH));
        if (!r_snap_valid || snap.snap_ready) begin
          r_snap_data  <= w_final;
          r_snap_valid <= 1'b1;
        end
      end else if (w_xfer) begin
        r_snap_valid <= 1'b0;
      end

      // A new overrun outranks a software clear in the same cycle.
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (i_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign snap.snap_data  = r_snap_data;
  assign snap.snap_valid = r_snap_valid;
  assign o_overrun       = r_overrun;
  assign o_alarm         = r_alarm;
  assign o_state         = r_state;

`ifdef SEQ_HIT_MON_TS_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_last_ts;
  logic        r_last_ts_vld;

  // Free-running cycle counter and capture of the latest counted hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt     <= '0;
      r_last_ts     <= '0;
      r_last_ts_vld <= 1'b0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_hit) begin
        r_last_ts     <= r_cyc_cnt;
        r_last_ts_vld <= 1'b1;
      end
    end
  end

  assign o_last_hit_ts     = r_last_ts;
  assign o_last_hit_ts_vld = r_last_ts_vld;
`endif

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Directed bench for seq_hit_monitor with WIN_LEN=8, THRESH=2, CNT_W=3.
import seq_mon_pkg::*;

module tb_seq_hit_monitor;

  localparam int CNT_W   = 3;
  localparam int TOT_W   = 16;
  localparam int WIN_LEN = 8;
  localparam int THRESH  = 2;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             hit_in;
  logic             clr;
  logic             overrun;
  logic             alarm;
  logic [TOT_W-1:0] total_cnt;
  state_t           state;
`ifdef SEQ_HIT_MON_TS_EN
  logic [31:0]      last_hit_ts;
  logic             last_hit_ts_vld;
`endif

  int n_checks = 0;
  int n_errors = 0;

  seq_hit_monitor_if #(.CNT_W(CNT_W)) snap_if ();

  seq_hit_monitor #(
    .CNT_W   (CNT_W),
    .TOT_W   (TOT_W),
    .WIN_LEN (WIN_LEN),
    .THRESH  (THRESH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_enable          (enable),
    .i_hit_in          (hit_in),
    .i_clr             (clr),
    .snap              (snap_if),
    .o_overrun         (overrun),
    .o_alarm           (alarm),
    .o_total_cnt       (total_cnt),
`ifdef SEQ_HIT_MON_TS_EN
    .o_last_hit_ts     (last_hit_ts),
    .o_last_hit_ts_vld (last_hit_ts_vld),
`endif
    .o_state           (state)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_snap(input string tag, input logic v, input int d,
                            input logic a, input logic o, input int t);
    check({tag, ".valid"},   32'(snap_if.snap_valid), 32'(v));
    check({tag, ".data"},    32'(snap_if.snap_data),  32'(d));
    check({tag, ".alarm"},   32'(alarm),              32'(a));
    check({tag, ".overrun"}, 32'(overrun),            32'(o));
    check({tag, ".total"},   32'(total_cnt),          32'(t));
  endtask

  // Drive window cycles first..last with hit/ready taken from the masks.
  task automatic cycles(input logic [7:0] hits, input logic [7:0] rdy,
                        input int first, input int last);
    for (int i = first; i <= last; i++) begin
      hit_in             = hits[i];
      snap_if.snap_ready = rdy[i];
      tick();
    end
    hit_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; hit_in = 1'b0; clr = 1'b0;
    snap_if.snap_ready = 1'b0;
    tick(); tick();
    check("reset.state", 32'(state), 32'(IDLE));
    check_snap("reset", 1'b0, 0, 1'b0, 1'b0, 0);
`ifdef SEQ_HIT_MON_TS_EN
    check("reset.ts_vld", 32'(last_hit_ts_vld), 32'd0);
`endif

    // Enable from IDLE: the hit in the IDLE cycle is ignored.
    rst = 1'b0; enable = 1'b1; hit_in = 1'b1;
    tick();
    hit_in = 1'b0;
    check("enable.state", 32'(state), 32'(RUN));
    check("enable.total", 32'(total_cnt), 32'd0);

    // Window 1: detector hits at cycles 4 and 6.
    cycles(8'b0101_0000, 8'hFF, 0, 7);
    check_snap("w1", 1'b1, 2, 1'b1, 1'b0, 2);

    // Window 2: snapshot consumed at once, so valid is a one-cycle pulse.
    cycles(8'b0000_0100, 8'hFF, 0, 0);
    check("w2.pulse", 32'(snap_if.snap_valid), 32'd0);
    cycles(8'b0000_0100, 8'hFF, 1, 7);
    check_snap("w2", 1'b1, 1, 1'b0, 1'b0, 3);

    // Window 3: hit every cycle saturates the window count at 7.
    cycles(8'hFF, 8'hFF, 0, 7);
    check_snap("w3", 1'b1, 7, 1'b1, 1'b0, 11);

    // Window 4: consume the previous snapshot, then stop accepting.
    cycles(8'b0000_0001, 8'b0000_0001, 0, 7);
    check_snap("w4", 1'b1, 1, 1'b0, 1'b0, 12);

    // Window 5: second window end with snapshot pending -> overrun.
    cycles(8'b0000_0011, 8'h00, 0, 6);
    check_snap("w5.hold", 1'b1, 1, 1'b0, 1'b0, 14);
    cycles(8'b0000_0011, 8'h00, 7, 7);
    check_snap("w5.end", 1'b1, 1, 1'b1, 1'b1, 14);

    // Window 6: clr together with a hit clears total and overrun.
    clr = 1'b1;
    cycles(8'b1000_0001, 8'hFF, 0, 0);
    clr = 1'b0;
    check_snap("w6.clr", 1'b0, 1, 1'b1, 1'b0, 0);
    // One earlier hit plus a hit on the window-end cycle.
    cycles(8'b1000_0001, 8'hFF, 1, 7);
    check_snap("w6.end", 1'b1, 2, 1'b1, 1'b0, 1);

    // Window 7: the new window starts from zero.
    cycles(8'h00, 8'hFF, 0, 7);
    check_snap("w7", 1'b1, 0, 1'b0, 1'b0, 1);

    // Window 8: overrun and clr in the same cycle, overrun wins.
    cycles(8'h00, 8'h00, 0, 6);
    clr = 1'b1;
    cycles(8'h00, 8'h00, 7, 7);
    clr = 1'b0;
    check_snap("w8", 1'b1, 0, 1'b0, 1'b1, 0);

    // Window 9: three hits, then enable drops at timer 5.
    cycles(8'b0000_0111, 8'b0000_0001, 0, 4);
    check("w9.total", 32'(total_cnt), 32'd3);
    enable = 1'b0; hit_in = 1'b1;
    tick();
    check("drop.state", 32'(state), 32'(IDLE));
    check_snap("drop", 1'b0, 0, 1'b0, 1'b1, 3);
    tick();
    check("idle.total", 32'(total_cnt), 32'd3);
    enable = 1'b1;
    tick();
    hit_in = 1'b0;
    check("reen.state", 32'(state), 32'(RUN));
    check("reen.total", 32'(total_cnt), 32'd3);

    // Full 8-cycle window after re-enable; partial count was discarded.
    cycles(8'b0000_0001, 8'hFF, 0, 6);
    check("w10.early", 32'(snap_if.snap_valid), 32'd0);
    cycles(8'b0000_0001, 8'hFF, 7, 7);
    check_snap("w10", 1'b1, 1, 1'b0, 1'b1, 4);

    // Window 11: leaves valid and alarm high before the reset.
    cycles(8'b0000_0011, 8'b0000_0001, 0, 7);
    check_snap("w11", 1'b1, 2, 1'b1, 1'b1, 6);

    // Reset mid-handshake drops everything.
    rst = 1'b1;
    tick();
    rst = 1'b0; enable = 1'b0;
    check("rst2.state", 32'(state), 32'(IDLE));
    check_snap("rst2", 1'b0, 0, 1'b0, 1'b0, 0);
    tick();
    check("rst2.lost", 32'(snap_if.snap_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
